// File: rtl/drc_axi_pkg.sv
// Shared AXI write-sink constants: response codes, burst/size encodings,
// FSM state encoding and the memory beat payload.
package drc_axi_pkg;

   localparam int unsigned BEAT_BITS = 128;
   localparam int unsigned STRB_BITS = BEAT_BITS / 8;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [2:0] AXI_SIZE_16B    = 3'b100;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic [BEAT_BITS-1:0] data;
      logic [STRB_BITS-1:0] be;
   } mem_beat_t;

endpackage

// File: rtl/drc_axi_addr_decode.sv
// Window check and word-address computation for one AW request.
module drc_axi_addr_decode
   import drc_axi_pkg::*;
#(
   parameter logic [31:0] p_base_addr   = 32'h0000_0000,
   parameter int unsigned p_depth_words = 1024,
   parameter int unsigned p_addr_bits   = 10
) (
   input  logic [31:0]            awaddr,
   input  logic [7:0]             awlen,
   input  logic [2:0]             awsize,
   input  logic [1:0]             awburst,
   output logic [p_addr_bits-1:0] word_c,
   output logic                   err_c
);

   localparam int unsigned AW = p_addr_bits;

   logic [32:0] diff_c;
   logic [32:0] last_word_c;
   logic        unused_c;

   // 33-bit difference so an address below the window shows up as bit 32.
   assign diff_c      = {1'b0, awaddr} - {1'b0, p_base_addr};
   assign last_word_c = {4'b0000, diff_c[32:4]} + 33'(awlen);
   assign word_c      = diff_c[AW+3:4];
   assign unused_c    = ^diff_c[3:0];

   assign err_c = (awsize != AXI_SIZE_16B)
                | (awburst != AXI_BURST_INCR)
                | diff_c[32]
                | (last_word_c >= 33'(p_depth_words));

endmodule

// File: rtl/drc_axi_write_sink.sv
// AXI4 write responder: accepts one INCR burst at a time, writes in-range
// beats to a word-addressed memory port and returns one B response per burst.
module drc_axi_write_sink
   import drc_axi_pkg::*;
#(
   parameter logic [31:0] p_base_addr   = 32'h0000_0000,
   parameter int unsigned p_depth_words = 1024,
   parameter int unsigned p_addr_bits   = 10
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [31:0]            awaddr,
   input  logic [7:0]             awlen,
   input  logic [2:0]             awsize,
   input  logic [1:0]             awburst,
   input  logic [3:0]             awcache,
   input  logic [2:0]             awproto,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [BEAT_BITS-1:0]   wdata,
   input  logic [STRB_BITS-1:0]   wstrb,
   input  logic                   wlast,
   input  logic                   wvalid,
   output logic                   wready,
   output logic [1:0]             bresp,
   output logic                   bvalid,
   input  logic                   bready,
   output logic                   mem_we,
   output logic [p_addr_bits-1:0] mem_addr,
   output logic [BEAT_BITS-1:0]   mem_wdata,
   output logic [STRB_BITS-1:0]   mem_be,
   output logic [31:0]            burst_count,
   output logic [15:0]            error_count
);

   localparam int unsigned AW = p_addr_bits;

   logic [1:0]    state, nxt_state;
   logic          err, nxt_err;
   logic [7:0]    beat_ctr, nxt_beat_ctr;
   logic [AW-1:0] word, nxt_word;
   logic          nxt_awready, nxt_wready, nxt_bvalid, nxt_mem_we;
   logic [1:0]    nxt_bresp;
   logic [AW-1:0] nxt_mem_addr;
   mem_beat_t     mem_beat, nxt_mem_beat;
   logic [31:0]   nxt_burst_count;
   logic [15:0]   nxt_error_count;

   logic [AW-1:0] dec_word_c;
   logic          dec_err_c;
   logic          burst_end_c;
   logic          mismatch_c;
   logic          unused_c;

   assign unused_c = ^{awcache, awproto};

   drc_axi_addr_decode #(
      .p_base_addr   (p_base_addr),
      .p_depth_words (p_depth_words),
      .p_addr_bits   (p_addr_bits)
   ) u_decode (
      .awaddr  (awaddr),
      .awlen   (awlen),
      .awsize  (awsize),
      .awburst (awburst),
      .word_c  (dec_word_c),
      .err_c   (dec_err_c)
   );

   // Burst ends on whichever comes first: last counted beat or wlast.
   assign burst_end_c = wlast | (beat_ctr == 8'd0);
   assign mismatch_c  = wlast ^ (beat_ctr == 8'd0);

   assign mem_wdata = mem_beat.data;
   assign mem_be    = mem_beat.be;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         err         <= 1'b0;
         beat_ctr    <= 8'd0;
         word        <= '0;
         awready     <= 1'b0;
         wready      <= 1'b0;
         bvalid      <= 1'b0;
         bresp       <= AXI_RESP_OKAY;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_beat    <= '0;
         burst_count <= 32'd0;
         error_count <= 16'd0;
      end else begin
         state       <= nxt_state;
         err         <= nxt_err;
         beat_ctr    <= nxt_beat_ctr;
         word        <= nxt_word;
         awready     <= nxt_awready;
         wready      <= nxt_wready;
         bvalid      <= nxt_bvalid;
         bresp       <= nxt_bresp;
         mem_we      <= nxt_mem_we;
         mem_addr    <= nxt_mem_addr;
         mem_beat    <= nxt_mem_beat;
         burst_count <= nxt_burst_count;
         error_count <= nxt_error_count;
      end
   end

   always_comb begin
      nxt_state       = state;
      nxt_err         = err;
      nxt_beat_ctr    = beat_ctr;
      nxt_word        = word;
      nxt_awready     = awready;
      nxt_wready      = wready;
      nxt_bvalid      = bvalid;
      nxt_bresp       = bresp;
      nxt_mem_we      = 1'b0;
      nxt_mem_addr    = mem_addr;
      nxt_mem_beat    = mem_beat;
      nxt_burst_count = burst_count;
      nxt_error_count = error_count;

      case (state)
         ST_IDLE: begin
            nxt_awready = 1'b1;
            nxt_wready  = 1'b0;
            nxt_bvalid  = 1'b0;
            if (awvalid && awready) begin
               nxt_awready  = 1'b0;
               nxt_wready   = 1'b1;
               nxt_beat_ctr = awlen;
               nxt_word     = dec_word_c;
               nxt_err      = dec_err_c;
               nxt_state    = ST_DATA;
            end
         end
         ST_DATA: begin
            if (wvalid && wready) begin
               // Mismatch only affects the response; this beat still writes.
               if (!err) begin
                  nxt_mem_we        = 1'b1;
                  nxt_mem_addr      = word;
                  nxt_mem_beat.data = wdata;
                  nxt_mem_beat.be   = wstrb;
               end
               nxt_word     = word + AW'(1);
               nxt_beat_ctr = beat_ctr - 8'd1;
               nxt_err      = err | mismatch_c;
               if (burst_end_c) begin
                  nxt_wready = 1'b0;
                  nxt_bvalid = 1'b1;
                  nxt_bresp  = (err | mismatch_c) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                  nxt_state  = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (bvalid && bready) begin
               nxt_bvalid      = 1'b0;
               nxt_burst_count = burst_count + 32'd1;
               if (bresp == AXI_RESP_SLVERR && error_count != 16'hFFFF)
                  nxt_error_count = error_count + 16'd1;
               nxt_err     = 1'b0;
               nxt_awready = 1'b1;
               nxt_state   = ST_IDLE;
            end
         end
         default: begin
            nxt_state = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_drc_axi_write_sink.sv
// Directed bench for drc_axi_write_sink: table of bursts plus hand-written
// sequences for wvalid gaps, delayed bready and reset mid-burst.
module tb_drc_axi_write_sink;
   import drc_axi_pkg::*;

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic [31:0]  awaddr = '0;
   logic [7:0]   awlen = '0;
   logic [2:0]   awsize = 3'b100;
   logic [1:0]   awburst = 2'b01;
   logic [3:0]   awcache = '0;
   logic [2:0]   awproto = '0;
   logic         awvalid = 1'b0;
   logic         awready;
   logic [127:0] wdata = '0;
   logic [15:0]  wstrb = '0;
   logic         wlast = 1'b0;
   logic         wvalid = 1'b0;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready = 1'b0;
   logic         mem_we;
   logic [9:0]   mem_addr;
   logic [127:0] mem_wdata;
   logic [15:0]  mem_be;
   logic [31:0]  burst_count;
   logic [15:0]  error_count;

   int checks = 0;
   int errors = 0;

   logic [9:0]   wr_addr[$];
   logic [127:0] wr_data[$];
   logic [15:0]  wr_be[$];

   always #5 i_clk = ~i_clk;

   drc_axi_write_sink dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awcache(awcache), .awproto(awproto), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .burst_count(burst_count), .error_count(error_count)
   );

   always @(negedge i_clk) begin
      if (mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
         wr_be.push_back(mem_be);
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          nbeats;
      bit          last_ok;
      int          exp_writes;
      int          exp_first;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [127:0] beat_data(input int tag, input int b);
      return {32'(tag), 32'(b), ~32'(tag), 32'hA5A5_0000 | 32'(b)};
   endfunction

   function automatic logic [15:0] beat_be(input int b);
      return 16'hFFFF ^ 16'(b);
   endfunction

   task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int nbeats, input bit last_ok, input int tag,
                            input int gap, input int bdelay,
                            output logic [1:0] resp, output int held);
      int t;
      resp = 2'bxx;
      held = 0;
      t = 0;
      while (!awready && t < 50) begin tick(); t++; end
      chk($sformatf("aw_wait tag%0d", tag), awready, 1'b1);
      if (!awready) return;
      awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         repeat (gap) tick();
         t = 0;
         while (!wready && t < 50) begin tick(); t++; end
         if (!wready) begin
            chk($sformatf("w_wait tag%0d beat%0d", tag, b), wready, 1'b1);
            return;
         end
         wvalid = 1'b1;
         wdata  = beat_data(tag, b);
         wstrb  = beat_be(b);
         wlast  = last_ok && (b == nbeats - 1);
         tick();
         wvalid = 1'b0;
         wlast  = 1'b0;
      end
      t = 0;
      while (!bvalid && t < 50) begin tick(); t++; end
      chk($sformatf("b_wait tag%0d", tag), bvalid, 1'b1);
      if (!bvalid) return;
      resp = bresp;
      repeat (bdelay) begin
         if (bvalid && bresp == resp) held++;
         tick();
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk($sformatf("b_drop tag%0d", tag), bvalid, 1'b0);
   endtask

   task automatic chk_writes(input int tag, input int n, input int first);
      chk($sformatf("nwrites tag%0d", tag), 128'(wr_addr.size()), 128'(n));
      for (int k = 0; k < wr_addr.size() && k < n; k++) begin
         chk($sformatf("waddr tag%0d k%0d", tag, k), 128'(wr_addr[k]), 128'(first + k));
         chk($sformatf("wdata tag%0d k%0d", tag, k), wr_data[k], beat_data(tag, k));
         chk($sformatf("wbe tag%0d k%0d", tag, k), 128'(wr_be[k]), 128'(beat_be(k)));
      end
   endtask

   task automatic clear_writes();
      wr_addr.delete();
      wr_data.delete();
      wr_be.delete();
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, " awready"}, awready, 1'b0);
      chk({tag, " wready"}, wready, 1'b0);
      chk({tag, " bvalid"}, bvalid, 1'b0);
      chk({tag, " bresp"}, bresp, 2'b00);
      chk({tag, " mem_we"}, mem_we, 1'b0);
      chk({tag, " mem_addr"}, mem_addr, 10'd0);
      chk({tag, " mem_wdata"}, mem_wdata, 128'd0);
      chk({tag, " burst_count"}, burst_count, 32'd0);
      chk({tag, " error_count"}, error_count, 16'd0);
   endtask

   initial begin
      logic [1:0] resp;
      int held;
      int exp_bursts;
      int exp_errs;

      //            addr          len   size    burst  nb last wr first resp
      vecs[0] = '{32'h0000_0010, 8'd0, 3'b100, 2'b01, 1, 1'b1, 1, 1,    2'b00};
      vecs[1] = '{32'h0000_0100, 8'd3, 3'b100, 2'b01, 4, 1'b1, 4, 16,   2'b00};
      vecs[2] = '{32'h0000_3FE0, 8'd3, 3'b100, 2'b01, 4, 1'b1, 0, 0,    2'b10};
      vecs[3] = '{32'h0000_0200, 8'd7, 3'b100, 2'b01, 4, 1'b1, 4, 32,   2'b10};
      vecs[4] = '{32'h0000_0300, 8'd1, 3'b011, 2'b01, 2, 1'b1, 0, 0,    2'b10};
      vecs[5] = '{32'h0000_0300, 8'd1, 3'b100, 2'b00, 2, 1'b1, 0, 0,    2'b10};
      vecs[6] = '{32'h0000_3FF0, 8'd0, 3'b100, 2'b01, 1, 1'b1, 1, 1023, 2'b00};
      vecs[7] = '{32'h0000_3FF0, 8'd1, 3'b100, 2'b01, 2, 1'b1, 0, 0,    2'b10};
      vecs[8] = '{32'h0000_0040, 8'd1, 3'b100, 2'b01, 2, 1'b0, 2, 4,    2'b10};
      vecs[9] = '{32'h0000_0000, 8'd1, 3'b100, 2'b01, 2, 1'b1, 2, 0,    2'b00};

      tick();
      tick();
      chk_outputs_zero("reset");
      i_rst_n = 1'b1;
      chk("awready_at_release", awready, 1'b0);
      tick();
      chk("awready_after_edge", awready, 1'b1);

      exp_bursts = 0;
      exp_errs   = 0;
      foreach (vecs[i]) begin
         clear_writes();
         run_burst(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                   vecs[i].nbeats, vecs[i].last_ok, i, 0, 0, resp, held);
         exp_bursts++;
         if (vecs[i].exp_resp == 2'b10) exp_errs++;
         chk($sformatf("bresp vec%0d", i), resp, vecs[i].exp_resp);
         chk_writes(i, vecs[i].exp_writes, vecs[i].exp_first);
         chk($sformatf("burst_count vec%0d", i), burst_count, 32'(exp_bursts));
         chk($sformatf("error_count vec%0d", i), error_count, 16'(exp_errs));
      end

      // 16 beats with wvalid every other cycle and bready held off 5 cycles.
      clear_writes();
      run_burst(32'h0, 8'd15, 3'b100, 2'b01, 16, 1'b1, 20, 1, 5, resp, held);
      chk("bresp long", resp, 2'b00);
      chk("bvalid_held long", 128'(held), 128'd5);
      chk_writes(20, 16, 0);
      chk("burst_count long", burst_count, 32'(exp_bursts + 1));

      // Reset after two of eight beats: no B response, counters cleared.
      clear_writes();
      awaddr = 32'h400; awlen = 8'd7; awsize = 3'b100; awburst = 2'b01; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         wvalid = 1'b1; wdata = beat_data(30, b); wstrb = beat_be(b);
         tick();
      end
      wvalid = 1'b0;
      chk("mem_we before reset", mem_we, 1'b1);
      #2 i_rst_n = 1'b0;
      #1 chk_outputs_zero("midreset");
      tick();
      tick();
      @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      chk("awready after midreset release", awready, 1'b0);
      chk("bvalid after midreset release", bvalid, 1'b0);
      tick();
      chk("awready midreset edge", awready, 1'b1);
      clear_writes();
      run_burst(32'h20, 8'd0, 3'b100, 2'b01, 1, 1'b1, 31, 0, 0, resp, held);
      chk("bresp after midreset", resp, 2'b00);
      chk_writes(31, 1, 2);
      chk("burst_count after midreset", burst_count, 32'd1);
      chk("error_count after midreset", error_count, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
